// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline-stage register with an optional two-entry skid buffer,
// synchronous flush with bubble insertion, and saturating stall/drop counters.
//
// state   | meaning
// EMPTY   | nothing stored, out_valid=0
// FULL    | one entry in the main register
// SKIDDED | main and skid registers both hold entries, in_ready=0
module pipe_stage_skid #(
  parameter int unsigned       CTRL_W      = 8,
  parameter int unsigned       DATA_W      = 64,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = '0,
  parameter bit                SKID        = 1'b1,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FULL    = 2'd1,
    SKIDDED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_n;
  logic [CTRL_W-1:0] m_ctrl, m_ctrl_n, s_ctrl, s_ctrl_n;
  logic [DATA_W-1:0] m_data, m_data_n, s_data, s_data_n;
  logic              rdy_q, rdy_n;
  logic              accept, consume;
  logic [1:0]        drop_inc;
  logic              stall_inc;
  logic [CNT_W:0]    drop_sum;

  assign out_valid = (state != EMPTY);
  assign out_ctrl  = out_valid ? m_ctrl : BUBBLE_CTRL;
  assign out_data  = m_data;

  // Without the skid register the only way to take a new entry while full is
  // to hand the current one downstream in the same cycle.
  assign in_ready  = SKID ? rdy_q : (!out_valid || out_ready);

  assign accept    = in_valid && in_ready;
  assign consume   = out_valid && out_ready;
  assign stall_inc = out_valid && !out_ready && !flush;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      FULL:    occupancy = 2'd1;
      SKIDDED: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_n  = state;
    m_ctrl_n = m_ctrl;
    m_data_n = m_data;
    s_ctrl_n = s_ctrl;
    s_data_n = s_data;
    drop_inc = 2'd0;
    if (flush) begin
      // An entry consumed this cycle still leaves downstream, so it is not a drop.
      state_n  = EMPTY;
      drop_inc = occupancy - 2'(consume) + 2'(accept);
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_n  = FULL;
            m_ctrl_n = in_ctrl;
            m_data_n = in_data;
          end
        end
        FULL: begin
          if (accept && consume) begin
            m_ctrl_n = in_ctrl;
            m_data_n = in_data;
          end else if (accept) begin
            if (SKID) begin
              state_n  = SKIDDED;
              s_ctrl_n = in_ctrl;
              s_data_n = in_data;
            end
          end else if (consume) begin
            state_n = EMPTY;
          end
        end
        SKIDDED: begin
          if (consume) begin
            state_n  = FULL;
            m_ctrl_n = s_ctrl;
            m_data_n = s_data;
          end
        end
        default: state_n = EMPTY;
      endcase
    end
  end

  assign rdy_n = (state_n != SKIDDED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= EMPTY;
      m_ctrl <= BUBBLE_CTRL;
      m_data <= '0;
      s_ctrl <= '0;
      s_data <= '0;
      rdy_q  <= 1'b1;
    end else begin
      state  <= state_n;
      m_ctrl <= m_ctrl_n;
      m_data <= m_data_n;
      s_ctrl <= s_ctrl_n;
      s_data <= s_data_n;
      rdy_q  <= rdy_n;
    end
  end

  assign drop_sum = {1'b0, drop_cnt} + (CNT_W+1)'(drop_inc);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else if (clr_stats) begin
      stall_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (stall_inc && (stall_cnt != CNT_MAX))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (drop_sum[CNT_W])
        drop_cnt <= CNT_MAX;
      else
        drop_cnt <= drop_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: instance 0 is SKID=1 with 4-bit counters, instance 1
// is SKID=0 with 16-bit counters; a FIFO model is compared on every negedge.
module tb_pipe_stage_skid;
  localparam int CW = 8;
  localparam int DW = 16;
  localparam logic [CW-1:0] BUB0 = 8'h5A;
  localparam logic [CW-1:0] BUB1 = 8'hC3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          iv [2];
  logic          ordy [2];
  logic          fl [2];
  logic          clr [2];
  logic [CW-1:0] ic [2];
  logic [DW-1:0] id [2];

  logic          rdy0, rdy1, ov0, ov1;
  logic [CW-1:0] oc0, oc1;
  logic [DW-1:0] od0, od1;
  logic [1:0]    occ0, occ1;
  logic [3:0]    stall0, drop0;
  logic [15:0]   stall1, drop1;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .BUBBLE_CTRL(BUB0), .SKID(1'b1), .CNT_W(4)) u_skid (
    .clk(clk), .rst(rst), .flush(fl[0]), .in_valid(iv[0]), .in_ready(rdy0),
    .in_ctrl(ic[0]), .in_data(id[0]), .out_valid(ov0), .out_ready(ordy[0]),
    .out_ctrl(oc0), .out_data(od0), .occupancy(occ0), .clr_stats(clr[0]),
    .stall_cnt(stall0), .drop_cnt(drop0));

  pipe_stage_skid #(.CTRL_W(CW), .DATA_W(DW), .BUBBLE_CTRL(BUB1), .SKID(1'b0), .CNT_W(16)) u_noskid (
    .clk(clk), .rst(rst), .flush(fl[1]), .in_valid(iv[1]), .in_ready(rdy1),
    .in_ctrl(ic[1]), .in_data(id[1]), .out_valid(ov1), .out_ready(ordy[1]),
    .out_ctrl(oc1), .out_data(od1), .occupancy(occ1), .clr_stats(clr[1]),
    .stall_cnt(stall1), .drop_cnt(drop1));

  // Model: a plain FIFO of {ctrl,data} per instance plus last presented data.
  logic [CW+DW-1:0] mq [2][4];
  int               mcnt [2];
  logic [DW-1:0]    mdat [2];
  int               mstall [2];
  int               mdrop [2];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int cmax(input int i);
    return (i == 0) ? 15 : 65535;
  endfunction

  function automatic bit exp_rdy(input int i);
    if (i == 0) return mcnt[i] < 2;
    return (mcnt[i] == 0) || ordy[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; mdat[i] = '0; mstall[i] = 0; mdrop[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit vld, acc, con;
    int drops;
    vld = mcnt[i] > 0;
    acc = iv[i] && exp_rdy(i);
    con = vld && ordy[i];
    if (fl[i]) begin
      drops = mcnt[i] - int'(con) + int'(acc);
      mcnt[i] = 0;
      mdrop[i] = (mdrop[i] + drops > cmax(i)) ? cmax(i) : mdrop[i] + drops;
    end else begin
      if (con) begin
        for (int k = 0; k < 3; k++) mq[i][k] = mq[i][k+1];
        mcnt[i]--;
      end
      if (acc) begin
        mq[i][mcnt[i]] = {ic[i], id[i]};
        mcnt[i]++;
      end
    end
    if (vld && !ordy[i] && !fl[i] && mstall[i] < cmax(i)) mstall[i]++;
    if (clr[i]) begin
      mstall[i] = 0; mdrop[i] = 0;
    end
    if (mcnt[i] > 0) mdat[i] = mq[i][0][DW-1:0];
  endtask

  always @(negedge rst) model_reset();

  always @(posedge clk) begin
    if (rst) begin
      model_step(0);
      model_step(1);
    end
  end

  task automatic cmp_inst(input int i, input logic ov, input logic rdy, input logic [CW-1:0] oc,
                          input logic [DW-1:0] od, input logic [1:0] occ, input int st, input int dr);
    bit ev;
    ev = mcnt[i] > 0;
    chk($sformatf("u%0d out_valid", i), 64'(ov), 64'(ev));
    chk($sformatf("u%0d in_ready", i), 64'(rdy), 64'(exp_rdy(i)));
    chk($sformatf("u%0d out_ctrl", i), 64'(oc),
        64'(ev ? mq[i][0][CW+DW-1:DW] : ((i == 0) ? BUB0 : BUB1)));
    chk($sformatf("u%0d out_data", i), 64'(od), 64'(mdat[i]));
    chk($sformatf("u%0d occupancy", i), 64'(occ), 64'(mcnt[i]));
    chk($sformatf("u%0d stall_cnt", i), 64'(st), 64'(mstall[i]));
    chk($sformatf("u%0d drop_cnt", i), 64'(dr), 64'(mdrop[i]));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, ov0, rdy0, oc0, od0, occ0, int'(stall0), int'(drop0));
    cmp_inst(1, ov1, rdy1, oc1, od1, occ1, int'(stall1), int'(drop1));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      iv[i] = 0; ordy[i] = 0; fl[i] = 0; clr[i] = 0; ic[i] = '0; id[i] = '0;
    end
    model_reset();
    repeat (2) tick();
    chk("rst out_valid", 64'(ov0), 0);
    chk("rst out_ctrl", 64'(oc0), 64'(8'h5A));
    chk("rst out_data", 64'(od0), 0);
    chk("rst in_ready", 64'(rdy0), 1);
    chk("rst occupancy", 64'(occ0), 0);
    chk("rst stall_cnt", 64'(stall0), 0);
    chk("rst noskid out_ctrl", 64'(oc1), 64'(8'hC3));
    chk("rst noskid in_ready", 64'(rdy1), 1);
    rst = 1'b1;
    tick();

    // Streaming
    ordy[0] = 1; iv[0] = 1;
    for (int k = 1; k <= 4; k++) begin
      id[0] = 16'(k); ic[0] = 8'(8'h10 + k);
      tick();
      chk("stream out_data", 64'(od0), 64'(k));
      chk("stream out_ctrl", 64'(oc0), 64'(8'h10 + k));
      chk("stream in_ready", 64'(rdy0), 1);
    end
    iv[0] = 0;
    tick();
    chk("stream drained", 64'(ov0), 0);
    chk("stream stall_cnt", 64'(stall0), 0);

    // Backpressure into the skid register
    ordy[0] = 0; iv[0] = 1; id[0] = 16'h00A; ic[0] = 8'hA1;
    tick();
    id[0] = 16'h00B; ic[0] = 8'hB2;
    tick();
    iv[0] = 0;
    chk("bp occupancy", 64'(occ0), 2);
    chk("bp in_ready", 64'(rdy0), 0);
    chk("bp head A", 64'(od0), 64'h00A);
    repeat (5) tick();
    chk("bp stall_cnt", 64'(stall0), 6);
    ordy[0] = 1;
    tick();
    chk("bp then B", 64'(od0), 64'h00B);
    chk("bp ctrl B", 64'(oc0), 64'(8'hB2));
    tick();
    chk("bp occupancy end", 64'(occ0), 0);
    chk("bp stall_cnt end", 64'(stall0), 6);

    // Flush while SKIDDED, then flush in FULL with accept and consume
    ordy[0] = 0; iv[0] = 1; id[0] = 16'h00C; ic[0] = 8'hC4;
    tick();
    id[0] = 16'h00D; ic[0] = 8'hD5;
    tick();
    iv[0] = 0; fl[0] = 1;
    tick();
    fl[0] = 0;
    chk("flush out_valid", 64'(ov0), 0);
    chk("flush bubble", 64'(oc0), 64'(8'h5A));
    chk("flush drop_cnt", 64'(drop0), 2);
    chk("flush stall_cnt", 64'(stall0), 7);
    chk("flush data kept", 64'(od0), 64'h00C);
    iv[0] = 1; ordy[0] = 1; id[0] = 16'h00E; ic[0] = 8'hE6;
    tick();
    chk("flush2 downstream sees E", 64'(od0), 64'h00E);
    chk("flush2 E valid", 64'(ov0), 1);
    fl[0] = 1; id[0] = 16'h00F; ic[0] = 8'hF7;
    tick();
    fl[0] = 0; iv[0] = 0;
    chk("flush2 drop_cnt", 64'(drop0), 3);
    chk("flush2 out_valid", 64'(ov0), 0);

    // Saturation and clear priority on 4-bit counters
    ordy[0] = 0; iv[0] = 1; id[0] = 16'h0110; ic[0] = 8'h21;
    tick();
    iv[0] = 0;
    repeat (20) tick();
    chk("sat stall_cnt", 64'(stall0), 15);
    clr[0] = 1;
    tick();
    clr[0] = 0;
    chk("clr stall_cnt", 64'(stall0), 0);
    chk("clr drop_cnt", 64'(drop0), 0);
    tick();
    chk("after clr stall_cnt", 64'(stall0), 1);
    fl[0] = 1;
    tick();
    fl[0] = 0;
    chk("after clr drop_cnt", 64'(drop0), 1);

    // SKID=0: combinational in_ready
    ordy[1] = 0; iv[1] = 1; id[1] = 16'h0111; ic[1] = 8'h31;
    tick();
    id[1] = 16'h0222; ic[1] = 8'h32;
    #1;
    chk("s0 in_ready low", 64'(rdy1), 0);
    ordy[1] = 1;
    #1;
    chk("s0 in_ready high", 64'(rdy1), 1);
    tick();
    chk("s0 new entry", 64'(od1), 64'h0222);
    chk("s0 occupancy", 64'(occ1), 1);
    iv[1] = 0;
    tick();
    chk("s0 drained", 64'(ov1), 0);
    iv[1] = 1; ordy[1] = 0; id[1] = 16'h0333; ic[1] = 8'h33;
    tick();
    iv[1] = 0; fl[1] = 1;
    tick();
    fl[1] = 0;
    chk("s0 drop_cnt", 64'(drop1), 1);

    // Asynchronous reset mid-stream
    ordy[0] = 0; iv[0] = 1; id[0] = 16'h0444; ic[0] = 8'h44;
    tick();
    id[0] = 16'h0555; ic[0] = 8'h55;
    tick();
    iv[0] = 0;
    chk("pre-rst occupancy", 64'(occ0), 2);
    #1 rst = 1'b0;
    #1;
    chk("arst out_valid", 64'(ov0), 0);
    chk("arst bubble", 64'(oc0), 64'(8'h5A));
    chk("arst stall_cnt", 64'(stall0), 0);
    chk("arst drop_cnt", 64'(drop0), 0);
    chk("arst occupancy", 64'(occ0), 0);
    chk("arst noskid drop_cnt", 64'(drop1), 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post-rst drop_cnt", 64'(drop0), 0);
    chk("post-rst in_ready", 64'(rdy0), 1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
